// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
//   Shares the single DDR4 controller memory port among NUM_REQ requesters.
//   A round-robin pick is made in IDLE and the winner's command is registered
//   onto the memory command port. The one-hot grant is then held until every
//   data beat of that burst has moved. The grant drives the external
//   write-data and read-data muxes. Runs entirely in the DDR user clock domain.
//
// Ports
//   CLK            DDR user clock
//   rstn           asynchronous active-low reset
//   req_valid      per-requester command valid
//   req_ready      per-requester command accept (pulses for the winner on handshake)
//   req_addr       packed addresses, requester i at [i*AW +: AW]
//   req_len        packed burst lengths (beats-1), requester i at [i*LW +: LW]
//   req_wr         per-requester direction, 1 = write burst
//   mem_cmd_valid  command to memory port valid
//   mem_cmd_ready  memory port accepts command
//   mem_cmd_addr   forwarded address
//   mem_cmd_len    forwarded burst length
//   mem_cmd_wr     forwarded direction
//   mem_cmd_id     index of the granted requester
//   mem_beat       one data beat of the granted burst completed this cycle
//   gnt            one-hot grant, all-zero when idle
//   busy           high whenever the arbiter is not idle

module ddr_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 34,
  parameter int LW      = 8,
  parameter int IDW     = 3
) (
  input  logic                  CLK,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*LW-1:0] req_len,
  input  logic [NUM_REQ-1:0]    req_wr,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [AW-1:0]         mem_cmd_addr,
  output logic [LW-1:0]         mem_cmd_len,
  output logic                  mem_cmd_wr,
  output logic [IDW-1:0]        mem_cmd_id,
  input  logic                  mem_beat,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA
  } state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_q;
  logic [LW-1:0] cnt_q;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  int            cand;

  // Round-robin search: the first valid requester at or after ptr_q, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  // Only the winner sees ready, and only in the handshake cycle itself.
  assign req_ready = (state_q == ISSUE && mem_cmd_ready) ? gnt : '0;
  assign busy      = (state_q != IDLE);

  // Arbitration FSM. The command is captured in IDLE so the memory port sees
  // stable values for the whole ISSUE phase, even if the requester misbehaves.
  // The beat counter holds beats-1 and the burst ends on a beat seen at zero,
  // which gives 2^LW beats for an all-ones length without any overflow.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      cnt_q         <= '0;
      gnt           <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
      mem_cmd_wr    <= 1'b0;
      mem_cmd_id    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            mem_cmd_addr  <= req_addr[int'(pick_idx)*AW +: AW];
            mem_cmd_len   <= req_len[int'(pick_idx)*LW +: LW];
            mem_cmd_wr    <= req_wr[pick_idx];
            mem_cmd_id    <= IDW'(pick_idx);
            win_q         <= pick_idx;
            gnt           <= ONE_HOT_0 << pick_idx;
            mem_cmd_valid <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          // A beat in the handshake cycle is deliberately not counted.
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            cnt_q         <= mem_cmd_len;
            state_q       <= DATA;
          end
        end
        DATA: begin
          if (mem_beat) begin
            if (cnt_q == '0) begin
              gnt     <= '0;
              ptr_q   <= (win_q == PW'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter
//   Directed bench for ddr_port_arbiter. Expected commands are queued when
//   stimulus is applied and a monitor pops and compares them on every command
//   handshake; the main sequence checks grant release and reset behaviour.

module tb_ddr_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 34;
  localparam int LW      = 8;
  localparam int IDW     = 3;

  logic                  CLK = 1'b0;
  logic                  rstn = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*LW-1:0] req_len = '0;
  logic [NUM_REQ-1:0]    req_wr = '0;
  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready = 1'b0;
  logic [AW-1:0]         mem_cmd_addr;
  logic [LW-1:0]         mem_cmd_len;
  logic                  mem_cmd_wr;
  logic [IDW-1:0]        mem_cmd_id;
  logic                  mem_beat = 1'b0;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;

  ddr_port_arbiter #(
    .NUM_REQ(NUM_REQ),
    .AW(AW),
    .LW(LW),
    .IDW(IDW)
  ) dut (
    .CLK(CLK),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_len(req_len),
    .req_wr(req_wr),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len),
    .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_id(mem_cmd_id),
    .mem_beat(mem_beat),
    .gnt(gnt),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [LW-1:0]      len;
    logic               wr;
    logic [IDW-1:0]     id;
    logic [NUM_REQ-1:0] gnt;
  } exp_t;

  exp_t expQ[$];
  int   checkCount  = 0;
  int   errorCount  = 0;
  int   readyPulses = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic wr);
    req_addr[idx*AW +: AW] = addr;
    req_len[idx*LW +: LW]  = len;
    req_wr[idx]            = wr;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic expectCmd(input int idx, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic wr);
    exp_t e;
    e.addr = addr;
    e.len  = len;
    e.wr   = wr;
    e.id   = IDW'(idx);
    e.gnt  = '0;
    e.gnt[idx] = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic waitIssue();
    int n = 0;
    while (!mem_cmd_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput("issue_timeout", mem_cmd_valid, 1);
  endtask

  task automatic beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      mem_beat = 1'b1;
      step();
      mem_beat = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Monitor: every command handshake must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (rstn) begin
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("cmd_expected", expQ.size(), 1);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("cmd_addr", mem_cmd_addr, e.addr);
          checkOutput("cmd_len", mem_cmd_len, e.len);
          checkOutput("cmd_wr", mem_cmd_wr, e.wr);
          checkOutput("cmd_id", mem_cmd_id, e.id);
          checkOutput("cmd_gnt", gnt, e.gnt);
          checkOutput("req_ready_pulse", req_ready, e.gnt);
          checkOutput("gnt_onehot", $onehot(gnt), 1);
        end
      end else begin
        checkOutput("req_ready_quiet", req_ready, 0);
      end
      if (|req_ready) readyPulses++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulseBase;

    // Reset state
    #1 rstn = 1'b0;
    #2;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cmd_valid", mem_cmd_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_cmd_addr", mem_cmd_addr, 0);
    checkOutput("rst_cmd_id", mem_cmd_id, 0);
    step();
    step();
    rstn = 1'b1;

    // Single request from requester 2
    $display("[TB] single request");
    pulseBase = readyPulses;
    mem_cmd_ready = 1'b1;
    applyStimulus(2, 34'h0_0000_1000, 8'd3, 1'b1);
    expectCmd(2, 34'h0_0000_1000, 8'd3, 1'b1);
    step();
    checkOutput("single_latency", mem_cmd_valid, 1);
    checkOutput("single_busy", busy, 1);
    step();
    req_valid = '0;
    checkOutput("single_ready_after", req_ready, 0);
    checkOutput("single_valid_dropped", mem_cmd_valid, 0);
    beats(3, 0);
    checkOutput("single_gnt_held", gnt, 4'b0100);
    beats(1, 0);
    checkOutput("single_gnt_release", gnt, 0);
    checkOutput("single_busy_release", busy, 0);
    checkOutput("single_ready_pulses", readyPulses - pulseBase, 1);

    // Round-robin with all four requesting
    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, AW'(34'h100 * (i + 1)), 8'd0, i[0]);
    expectCmd(0, 34'h100, 8'd0, 1'b0);
    expectCmd(1, 34'h200, 8'd0, 1'b1);
    expectCmd(2, 34'h300, 8'd0, 1'b0);
    expectCmd(3, 34'h400, 8'd0, 1'b1);
    expectCmd(0, 34'h100, 8'd0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      waitIssue();
      step();
      if (g == 4) req_valid = '0;
      beats(1, 0);
    end
    checkOutput("rr_idle", busy, 0);

    // Backpressure on the command port
    $display("[TB] backpressure");
    pulseBase = readyPulses;
    mem_cmd_ready = 1'b0;
    applyStimulus(1, 34'h2_0000_0040, 8'd2, 1'b1);
    expectCmd(1, 34'h2_0000_0040, 8'd2, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", mem_cmd_valid, 1);
      checkOutput("bp_addr", mem_cmd_addr, 34'h2_0000_0040);
      checkOutput("bp_len", mem_cmd_len, 2);
      checkOutput("bp_id", mem_cmd_id, 1);
      checkOutput("bp_ready", req_ready, 0);
      if (c == 0) req_addr[1*AW +: AW] = 34'h3_DEAD_BEE0;
      step();
    end
    mem_cmd_ready = 1'b1;
    step();
    req_valid = '0;
    beats(3, 0);
    checkOutput("bp_release", gnt, 0);
    checkOutput("bp_ready_pulses", readyPulses - pulseBase, 1);

    // Maximum burst length, back-to-back then gapped beats
    $display("[TB] max burst");
    for (int gap = 0; gap < 2; gap++) begin
      applyStimulus(3, 34'h3_FFFF_F000, 8'hFF, 1'b0);
      expectCmd(3, 34'h3_FFFF_F000, 8'hFF, 1'b0);
      waitIssue();
      step();
      req_valid = '0;
      beats(255, gap);
      checkOutput("max_held_255", gnt, 4'b1000);
      checkOutput("max_busy_255", busy, 1);
      beats(1, gap);
      checkOutput("max_release_256", gnt, 0);
      checkOutput("max_idle_256", busy, 0);
    end

    // Stray beats in IDLE and ISSUE are ignored
    $display("[TB] stray beats");
    mem_beat = 1'b1;
    step();
    step();
    checkOutput("stray_idle_busy", busy, 0);
    mem_cmd_ready = 1'b0;
    applyStimulus(0, 34'h0_0000_0800, 8'd1, 1'b1);
    expectCmd(0, 34'h0_0000_0800, 8'd1, 1'b1);
    step();
    step();
    checkOutput("stray_issue_valid", mem_cmd_valid, 1);
    mem_cmd_ready = 1'b1;
    step();
    mem_beat  = 1'b0;
    req_valid = '0;
    beats(1, 0);
    checkOutput("stray_gnt_held", gnt, 4'b0001);
    checkOutput("stray_busy_held", busy, 1);
    beats(1, 0);
    checkOutput("stray_release", gnt, 0);

    // Asynchronous reset in the middle of a burst
    $display("[TB] async reset");
    applyStimulus(2, 34'h1_2345_6780, 8'd7, 1'b0);
    expectCmd(2, 34'h1_2345_6780, 8'd7, 1'b0);
    waitIssue();
    step();
    req_valid = '0;
    beats(2, 0);
    checkOutput("ar_before", gnt, 4'b0100);
    #2 rstn = 1'b0;
    #1;
    checkOutput("ar_gnt", gnt, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_cmd_valid", mem_cmd_valid, 0);
    checkOutput("ar_cmd_addr", mem_cmd_addr, 0);
    #2 rstn = 1'b1;
    step();
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, AW'(34'h5000 + 34'h10 * i), 8'd0, 1'b1);
    expectCmd(0, 34'h5000, 8'd0, 1'b1);
    waitIssue();
    step();
    req_valid = '0;
    beats(1, 0);
    step();
    step();
    checkOutput("queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR4 controller memory port among NUM_REQ requesters (kernels and network bridges) in the shell.
- Each requester issues one burst command at a time. The block picks a winner round-robin, forwards the command to the memory port and holds the grant until every data beat of that burst has moved.
- The one-hot grant steers the write-data and read-data muxes outside this block. It runs in the DDR user clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, 34, byte address width
LW, 8, burst length field width (AXI-style: beats = len+1)
IDW, 3, command ID width; must satisfy 2^IDW >= NUM_REQ

Ports:
CLK  in  1  DDR user clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept
req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_len  in  NUM_REQ*LW  packed burst lengths (beats-1)
req_wr  in  NUM_REQ  1=write burst, 0=read burst
mem_cmd_valid  out  1  command to memory port valid
mem_cmd_ready  in  1  memory port accepts command
mem_cmd_addr  out  AW  forwarded address
mem_cmd_len  out  LW  forwarded length
mem_cmd_wr  out  1  forwarded direction
mem_cmd_id  out  IDW  index of the granted requester
mem_beat  in  1  one data beat completed this cycle (wvalid&wready, or rvalid&rready, of the granted burst)
gnt  out  NUM_REQ  one-hot grant; all-zero when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, gnt=0, mem_cmd_valid=0, req_ready=0, busy=0, beat counter=0, round-robin pointer=0. mem_cmd_addr, mem_cmd_len, mem_cmd_wr and mem_cmd_id are 0.
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - If any req_valid is high, select the first requester with req_valid high, searching from index ptr upward with wrap-around.
  - Register its addr, len, wr and index into the mem_cmd_* outputs and set gnt one-hot. Go to ISSUE on the next edge.
  - Arbitration latency is one cycle from req_valid to mem_cmd_valid.
- ISSUE:
  - mem_cmd_valid=1.
  - When mem_cmd_ready=1: req_ready[winner] pulses high for that same cycle only (combinational on mem_cmd_ready and state), load beat counter with len, go to DATA, drop mem_cmd_valid.
  - mem_cmd_* stay stable while in ISSUE.
- DATA:
  - gnt is held. Each cycle mem_beat=1 decrements the counter.
  - When mem_beat=1 and the counter is 0 (last beat), go to IDLE, clear gnt and set ptr = winner+1 mod NUM_REQ.
  - The earliest new grant comes one cycle after the last beat (a one-cycle bubble is accepted).
- mem_beat outside DATA is ignored. A beat in the same cycle as the command handshake is not counted; the memory port guarantees data follows the command.
- A requester deasserting req_valid while in ISSUE is a protocol violation. The command is already captured and issues regardless.
- req_ready is 0 for all non-winners at all times.
- A single-beat burst (len=0) is legal: the first mem_beat in DATA returns the FSM to IDLE.
- Length counter width is LW; a len of all-ones gives 2^LW beats with no overflow.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 bursts.
- Reset mid-burst aborts immediately with gnt=0. The memory controller is reset by the same rstn.

Test Plan:
- Single request: req_valid[2]=1, addr=0x1000, len=3, wr=1, mem_cmd_ready=1 -> one cycle later mem_cmd_valid=1, id=2, gnt=4'b0100, req_ready[2] pulses 1 cycle. After 4 mem_beat pulses gnt=0, busy=0.
- Round-robin: all four req_valid held high, len=0, one beat each -> grant order 0,1,2,3,0. Every gnt is one-hot and never overlaps.
- Backpressure: mem_cmd_ready low for 5 cycles -> mem_cmd_valid stays 1, addr/len/id stable, req_ready stays 0. Accept on cycle 6 gives exactly one req_ready pulse.
- Max burst: len=8'hFF -> grant released exactly after beat 256, not 255 or 257. Gapped mem_beat (every other cycle) gives the same count.
- Stray beats: mem_beat pulses in IDLE and during ISSUE -> counter unaffected; burst of len=1 still needs 2 beats in DATA.
- Async reset: assert rstn low mid-DATA between clock edges -> gnt, busy and mem_cmd_valid go to 0 without waiting for CLK. After release, the next grant goes to requester 0.
